uart_tx_serializer: RTL

//   Parametrised parallel-to-serial shifter for the UART transmit path.

---
 rtl/uart_tx_serializer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   Parallel-to-serial shifter for the UART transmit path. A DATA_WIDTH word
//   is captured on a DATA_VALID/READY handshake. It is then emitted one bit
//   per SER_TICK baud strobe, either LSB first or MSB first. A closing bit
//   period ends with a one-cycle SER_DONE pulse, which lets the TX FSM
//   sequence stop/idle.
//
//   Optional feature macro: UART_SER_PARITY_EN
//     defined   -> PAR_TYP port and PARITY state exist. One parity bit
//                  (^P_DATA ^ PAR_TYP, captured at accept) follows the data.
//     undefined -> SHIFT goes straight to CLOSE.
//
//   All outputs are registered. RST is asynchronous and active-low.
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  SER_TICK,
`ifdef UART_SER_PARITY_EN
    input  logic                  PAR_TYP,
`endif
    output logic                  READY,
    output logic                  BUSY,
    output logic                  SER_OUT,
    output logic                  SER_DONE
);

    // Counter wide enough to hold DATA_WIDTH
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    // Counter value seen on the tick that emits the final data bit
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef UART_SER_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_CLOSE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Bit that leaves the shift register on the next tick
    function automatic logic next_bit(input logic [DATA_WIDTH-1:0] shreg);
        logic bit_v;
        if (LSB_FIRST) begin
            bit_v = shreg[0];
        end else begin
            bit_v = shreg[DATA_WIDTH-1];
        end
        return bit_v;
    endfunction

    // Shift register contents after one bit has been emitted
    function automatic logic [DATA_WIDTH-1:0] shift_once(input logic [DATA_WIDTH-1:0] shreg);
        logic [DATA_WIDTH-1:0] res_v;
        if (LSB_FIRST) begin
            res_v = {1'b0, shreg[DATA_WIDTH-1:1]};
        end else begin
            res_v = {shreg[DATA_WIDTH-2:0], 1'b0};
        end
        return res_v;
    endfunction

`ifdef UART_SER_PARITY_EN
    // Frame parity: even when odd_sel is 0, odd when odd_sel is 1
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic                  odd_sel);
        return (^data) ^ odd_sel;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ser_out;
    logic                  r_ser_done;
    logic                  r_ready;
    logic                  r_busy;
`ifdef UART_SER_PARITY_EN
    logic                  r_parity;
`endif

    // Next-state values
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shreg_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_ser_out_nxt;
    logic                  w_ser_done_nxt;
    logic                  w_ready_nxt;
    logic                  w_busy_nxt;
    logic                  w_accept;
`ifdef UART_SER_PARITY_EN
    logic                  w_parity_nxt;
`endif

    // Handshake completes only while idle with READY already visible upstream
    assign w_accept = DATA_VALID && r_ready && (r_state == ST_IDLE);

    // Register all state, datapath and output flops
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_ser_out  <= 1'b0;
            r_ser_done <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
`ifdef UART_SER_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ser_out  <= w_ser_out_nxt;
            r_ser_done <= w_ser_done_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
`ifdef UART_SER_PARITY_EN
            r_parity   <= w_parity_nxt;
`endif
        end
    end

    // Next-state and next-output logic of the frame sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_cnt_nxt      = r_cnt;
        w_ser_out_nxt  = r_ser_out;
        w_ser_done_nxt = 1'b0;
`ifdef UART_SER_PARITY_EN
        w_parity_nxt   = r_parity;
`endif

        case (r_state)
            ST_IDLE: begin
                // Line rests low while idle; ticks are ignored here
                w_ser_out_nxt = 1'b0;
                if (w_accept) begin
                    w_shreg_nxt = P_DATA;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
`ifdef UART_SER_PARITY_EN
                    // Parity is frozen here so later PAR_TYP/P_DATA moves cannot disturb it
                    w_parity_nxt = calc_parity(P_DATA, PAR_TYP);
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (SER_TICK) begin
                    w_ser_out_nxt = next_bit(r_shreg);
                    w_shreg_nxt   = shift_once(r_shreg);
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_IDX) begin
`ifdef UART_SER_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_CLOSE;
`endif
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end

`ifdef UART_SER_PARITY_EN
            ST_PARITY: begin
                if (SER_TICK) begin
                    w_ser_out_nxt = r_parity;
                    w_state_nxt   = ST_CLOSE;
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
`endif

            ST_CLOSE: begin
                // The tick here ends the last bit period of the frame
                if (SER_TICK) begin
                    w_ser_out_nxt  = 1'b0;
                    w_ser_done_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLOSE;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_ser_out_nxt = 1'b0;
                w_cnt_nxt     = '0;
            end
        endcase
    end

    // READY trails entry into IDLE by one cycle, so it returns the cycle after
    // SER_DONE. BUSY is its complement.
    always_comb begin
        w_ready_nxt = 1'b0;
        if ((r_state == ST_IDLE) && !w_accept) begin
            w_ready_nxt = 1'b1;
        end else begin
            w_ready_nxt = 1'b0;
        end
        w_busy_nxt = !w_ready_nxt;
    end

    assign READY    = r_ready;
    assign BUSY     = r_busy;
    assign SER_OUT  = r_ser_out;
    assign SER_DONE = r_ser_done;

endmodule
